// File: rtl/cnn_acc_pkg.sv
// Shared widths, FSM state type and the ReLU/saturation helper for the
// conv channel accumulator controller.
package cnn_acc_pkg;

  localparam int unsigned W1         = 21;  // signed product width per lane
  localparam int unsigned W2         = 24;  // exact width of the 8-lane sum
  localparam int unsigned ACC_W      = 32;  // accumulator width, cannot wrap
  localparam int unsigned OUT_W      = 24;  // result width after ReLU/saturation
  localparam int unsigned MAX_GROUPS = 16;  // max beats per output pixel
  localparam int unsigned GW         = 5;   // width of group count fields
  localparam int unsigned LANES      = 8;   // products per beat

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Optional ReLU followed by a clamp into the signed OUT_W range.
  function automatic logic signed [OUT_W-1:0] sat_relu(
    input logic signed [ACC_W-1:0] acc,
    input logic                    relu_en
  );
    logic signed [ACC_W-1:0] max_v;
    logic signed [ACC_W-1:0] min_v;
    logic signed [ACC_W-1:0] res;
    max_v = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    min_v = ~max_v;
    res   = acc;
    if (relu_en && acc[ACC_W-1]) begin
      res = '0;
    end else if (acc > max_v) begin
      res = max_v;
    end else if (acc < min_v) begin
      res = min_v;
    end
    return res[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/conv_channel_acc_ctrl_if.sv
// Stream interface of the accumulator controller.
//   in_valid/in_ready/in_data    : product beats from the multiplier array
//   out_valid/out_ready/out_data : finished pixel result towards the writer
// slave = the controller side, master = the side feeding beats and taking results.
interface conv_channel_acc_ctrl_if;
  import cnn_acc_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*W1-1:0]       in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [OUT_W-1:0]   out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/conv_channel_acc_ctrl_add8.sv
// Combinational 8-input signed adder over packed lanes.
//   in_data_i : 8 signed lanes, lane k = in_data_i[k*w1 +: w1]
//   sum_o     : signed w2-bit sum (w2 >= w1+3 keeps it exact)
module conv_channel_acc_ctrl_add8 #(
  parameter int unsigned w1 = 21,
  parameter int unsigned w2 = 24
) (
  input  logic [8*w1-1:0]       in_data_i,
  output logic signed [w2-1:0]  sum_o
);

  // Sign-extend every lane to the sum width before adding.
  always_comb begin
    sum_o = '0;
    for (int k = 0; k < 8; k++) begin
      sum_o = sum_o + w2'($signed(in_data_i[k*w1 +: w1]));
    end
  end

endmodule

// File: rtl/conv_channel_acc_ctrl.sv
// Sequences the 8-input adder over cfg_groups beats for one conv output pixel:
// seeds the accumulator with the bias, adds one 8-lane sum per accepted beat,
// then presents the ReLU'd, saturated result downstream.
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : begin a job (only honoured in IDLE)
//   cfg_groups   : beats per job, legal 1..MAX_GROUPS, latched on start
//   bias         : signed bias, latched on start
//   relu_en      : clamp negatives to 0, latched on start
//   bus          : beat input and result output streams (slave side)
//   busy         : job in progress (ACC or OUT)
//   done         : one-cycle pulse the cycle after the result handshake
//   err_cfg      : one-cycle pulse after a start with illegal cfg_groups
module conv_channel_acc_ctrl
  import cnn_acc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [GW-1:0]           cfg_groups,
  input  logic signed [OUT_W-1:0] bias,
  input  logic                    relu_en,
  conv_channel_acc_ctrl_if.slave  bus,
  output logic                    busy,
  output logic                    done,
  output logic                    err_cfg
);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [GW-1:0]           cnt_q, cnt_d;
  logic [GW-1:0]           groups_q, groups_d;
  logic                    relu_q, relu_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic signed [W2-1:0]    sum8;
  logic signed [ACC_W-1:0] acc_sum;
  logic                    beat;

  conv_channel_acc_ctrl_add8 #(
    .w1 (W1),
    .w2 (W2)
  ) u_add8 (
    .in_data_i (bus.in_data),
    .sum_o     (sum8)
  );

  assign beat    = bus.in_valid && in_ready_q;
  assign acc_sum = acc_q + ACC_W'(sum8);

  // Next state, datapath updates and registered output decode.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    groups_d   = groups_q;
    relu_d     = relu_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ((cfg_groups == '0) || (cfg_groups > GW'(MAX_GROUPS))) begin
            err_d = 1'b1;
          end else begin
            groups_d = cfg_groups;
            relu_d   = relu_en;
            acc_d    = ACC_W'(bias);
            cnt_d    = '0;
            state_d  = ACC;
          end
        end
      end
      ACC: begin
        if (beat) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + GW'(1);
          // Last beat: result is taken from the running sum, not acc_q.
          if (cnt_q == groups_q - GW'(1)) begin
            out_data_d = sat_relu(acc_sum, relu_q);
            state_d    = OUT;
          end
        end
      end
      OUT: begin
        if (out_valid_q && bus.out_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status flags are registered copies of the upcoming state.
    in_ready_d  = (state_d == ACC);
    out_valid_d = (state_d == OUT);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      groups_q    <= '0;
      relu_q      <= 1'b0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      groups_q    <= groups_d;
      relu_q      <= relu_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_cfg       = err_q;

endmodule

// File: tb/tb_conv_channel_acc_ctrl.sv
// Directed and randomized checks of conv_channel_acc_ctrl against an
// arithmetic reference model (sum of all lanes plus bias, ReLU, clamp).
module tb_conv_channel_acc_ctrl;
  import cnn_acc_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic [GW-1:0]           cfg_groups = '0;
  logic signed [OUT_W-1:0] bias = '0;
  logic                    relu_en = 1'b0;
  logic                    busy, done, err_cfg;

  conv_channel_acc_ctrl_if bus();

  conv_channel_acc_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_groups (cfg_groups),
    .bias       (bias),
    .relu_en    (relu_en),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err_cfg    (err_cfg)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic signed [W1-1:0] lanes [MAX_GROUPS][LANES];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < int'(MAX_GROUPS); i++)
      for (int k = 0; k < int'(LANES); k++)
        lanes[i][k] = W1'(v);
  endtask

  task automatic set_beat(input int i);
    for (int k = 0; k < int'(LANES); k++)
      bus.in_data[k*W1 +: W1] = lanes[i][k];
  endtask

  // Expected pixel value straight from the arithmetic definition.
  function automatic longint model(input int g, input int b, input bit relu);
    longint s;
    longint hi;
    s  = longint'(b);
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    for (int i = 0; i < g; i++)
      for (int k = 0; k < int'(LANES); k++)
        s += longint'(lanes[i][k]);
    if (relu && s < 0) s = 0;
    if (s > hi) s = hi;
    if (s < -hi - 1) s = -hi - 1;
    return s;
  endfunction

  // gap: 0 = valid every cycle, 1 = valid 1-of-2, 2 = random gaps.
  task automatic run_job(input string tag, input int g, input int b, input bit relu,
                         input int gap, input int stall, input logic signed [63:0] exp);
    int sent;
    int cyc;
    logic took;
    sent = 0;
    cyc  = 0;
    cfg_groups = GW'(g);
    bias       = OUT_W'(b);
    relu_en    = relu;
    start      = 1'b1;
    step();
    start      = 1'b0;
    cfg_groups = '0;
    bias       = '0;
    relu_en    = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    while (sent < g && cyc < 400) begin
      if (gap == 1)      bus.in_valid = (cyc % 2 == 0);
      else if (gap == 2) bus.in_valid = ($urandom_range(99) >= 40);
      else               bus.in_valid = 1'b1;
      set_beat(sent);
      took = bus.in_valid && bus.in_ready;
      step();
      cyc++;
      if (took) sent++;
    end
    if (sent < g) chk({tag, "_beat_timeout"}, sent, g);
    // Keep offering beats: none may be consumed once the result is pending.
    bus.in_valid = 1'b1;
    chk({tag, "_out_valid"}, bus.out_valid, 1);
    chk({tag, "_out_data"}, bus.out_data, exp);
    chk({tag, "_in_ready_off"}, bus.in_ready, 0);
    for (int s = 0; s < stall; s++) begin
      bus.out_ready = 1'b0;
      start         = 1'b1;
      cfg_groups    = GW'($urandom_range(1, MAX_GROUPS));
      step();
      chk({tag, "_stall_valid"}, bus.out_valid, 1);
      chk({tag, "_stall_data"}, bus.out_data, exp);
      chk({tag, "_stall_rdy"}, bus.in_ready, 0);
      chk({tag, "_stall_done"}, done, 0);
    end
    start         = 1'b0;
    cfg_groups    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_hs_valid"}, bus.out_valid, 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_idle"}, busy, 0);
    step();
    chk({tag, "_done_once"}, done, 0);
    chk({tag, "_still_idle"}, busy, 0);
  endtask

  initial begin
    int g;
    int b;
    bit r;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data   = '0;

    // Reset values.
    step();
    step();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_cfg, 0);
    rst_n = 1'b1;
    step();

    // Single beat, lanes 1..8.
    for (int k = 0; k < int'(LANES); k++) lanes[0][k] = W1'(k + 1);
    run_job("t1", 1, 0, 1'b0, 0, 0, 36);

    // Three gapped beats with negative bias.
    fill_const(100);
    run_job("t2", 3, -10, 1'b0, 1, 2, 2390);

    // ReLU on and off.
    fill_const(-1000);
    run_job("t3_relu", 2, 0, 1'b1, 0, 0, 0);
    run_job("t3_norelu", 2, 0, 1'b0, 0, 1, -16000);

    // Saturation at both ends with the maximum group count.
    fill_const((1 << 20) - 1);
    run_job("t4_pos", 16, 0, 1'b0, 0, 0, 8388607);
    fill_const(-(1 << 20));
    run_job("t4_neg", 16, 0, 1'b0, 2, 0, -8388608);

    // Backpressure with ignored start pulses.
    fill_const(7);
    run_job("t5_bp", 2, 3, 1'b0, 0, 5, 115);

    // Illegal group counts.
    cfg_groups = GW'(0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("err0_pulse", err_cfg, 1);
    chk("err0_busy", busy, 0);
    chk("err0_rdy", bus.in_ready, 0);
    step();
    chk("err0_clear", err_cfg, 0);
    chk("err0_busy2", busy, 0);
    cfg_groups = GW'(17);
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_groups = '0;
    chk("err17_pulse", err_cfg, 1);
    chk("err17_busy", busy, 0);
    step();
    chk("err17_clear", err_cfg, 0);

    // Reset in the middle of a job.
    fill_const(50);
    cfg_groups = GW'(4);
    start = 1'b1;
    step();
    start = 1'b0;
    bus.in_valid = 1'b1;
    set_beat(0);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    chk("mid_rst_rdy", bus.in_ready, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err_cfg, 0);
    step();
    chk("mid_rst_nodone", done, 0);
    fill_const(1);
    run_job("t6_after", 1, 5, 1'b0, 0, 0, 13);

    // Randomized jobs against the reference model.
    for (int j = 0; j < 24; j++) begin
      g = int'($urandom_range(1, MAX_GROUPS));
      b = int'($urandom_range(32'h00FF_FFFF)) - (1 << 23);
      r = 1'($urandom_range(1));
      for (int i = 0; i < int'(MAX_GROUPS); i++)
        for (int k = 0; k < int'(LANES); k++)
          lanes[i][k] = (j % 2 == 0) ? W1'($urandom)
                                     : W1'(int'($urandom_range(2000)) - 1000);
      run_job("rnd", g, b, r, 2, int'($urandom_range(3)), model(g, b, r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
